// File: rtl/jts16b_busarb_pkg.sv
// rtl/jts16b_busarb_pkg.sv - shared types and defaults for the S16B bus arbiter
//
// Purpose: FSM state encoding, parameter defaults and requester indices
//          used by jts16b_busarb and its round-robin picker.
// Ports:   none (package).

package jts16b_busarb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_OWN     = 3'd2,
      ST_ACCESS  = 3'd3,
      ST_DONE    = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   localparam int WAITCYC_DEF = 3;
   localparam int TIMEOUT_DEF = 255;
   localparam int CHAIN_DEF   = 1;

   localparam logic REQ_MCU = 1'b0;   // MCU mapper transfer
   localparam logic REQ_DBG = 1'b1;   // debug/status port

endpackage

// File: rtl/jts16b_busarb_rr.sv
// rtl/jts16b_busarb_rr.sv - two-way round-robin picker with last-winner memory
//
// Purpose: chooses which requester gets the next grant. A lone request
//          always wins; when both are pending the one that did not win
//          last time is chosen.
// Ports:   clk, rst      clock, async active-high reset
//          req[1:0]     request levels
//          upd          pulse: an access has been acknowledged
//          upd_idx      requester that was acknowledged
//          pick         selected requester (valid while req != 0)

module jts16b_busarb_rr
   import jts16b_busarb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_idx,
   output logic       pick
);

   logic last_winner;

   // Reset to the debug port so a simultaneous first request goes to the MCU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_winner <= REQ_DBG;
      else if (upd)
         last_winner <= upd_idx;
   end

   always_comb begin
      pick = ~last_winner;
      if (req == 2'b01)
         pick = REQ_MCU;
      else if (req == 2'b10)
         pick = REQ_DBG;
   end

endmodule

// File: rtl/jts16b_busarb.sv
// rtl/jts16b_busarb.sv - 68000 bus-sharing arbiter for the 315-5195 mapper
//
// Purpose: requests the 68000 bus via BR/BG/BGACK on behalf of two DMA
//          requesters, performs one word access per grant and returns the
//          read data with a one-clock ack (err flags a grant timeout).
// Ports:   clk, rst, cen               clock, async reset, 68000 clock enable
//          cpu_rst, cpu_haltn          68000 state; either makes the bus free
//          cpu_brn/bgn/bgackn          bus request handshake
//          cpu_asn, cpu_dtackn         68000 bus activity
//          req, rnw, addr0/1, wdata0/1 requester side
//          ack, err, rdata             completion
//          owner                       1 while this block drives the bus
//          bus_addr/din/rnw/asn/dsn    memory-side access
//          bus_dout, bus_busy          memory-side response

module jts16b_busarb
   import jts16b_busarb_pkg::*;
#(
   parameter int WAITCYC = WAITCYC_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CHAIN   = CHAIN_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        cpu_rst,
   input  logic        cpu_haltn,
   output logic        cpu_brn,
   input  logic        cpu_bgn,
   output logic        cpu_bgackn,
   input  logic        cpu_asn,
   input  logic        cpu_dtackn,
   input  logic [1:0]  req,
   input  logic [1:0]  rnw,
   input  logic [22:0] addr0,
   input  logic [22:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic [1:0]  ack,
   output logic        err,
   output logic [15:0] rdata,
   output logic        owner,
   output logic [22:0] bus_addr,
   output logic [15:0] bus_din,
   output logic        bus_rnw,
   output logic        bus_asn,
   output logic [1:0]  bus_dsn,
   input  logic [15:0] bus_dout,
   input  logic        bus_busy
);

   localparam logic [2:0] WAIT_INIT = 3'(WAITCYC);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
   localparam bit         CHAIN_EN  = (CHAIN != 0);

   state_t      st, st_n;
   logic        winner, winner_n;
   logic [22:0] lat_addr, addr_n;
   logic [15:0] lat_din, din_n;
   logic        lat_rnw, rnw_n;
   logic [7:0]  tmo_cnt, tmo_n;
   logic [2:0]  wait_cnt, wait_n;
   logic        bus_quiet, quiet_n;
   logic        brn_n, bgackn_n, err_n, owner_n, brnw_n, basn_n;
   logic [1:0]  ack_n, bdsn_n;
   logic [15:0] rdata_n, bdin_n;
   logic [22:0] baddr_n;
   logic        pick;
   logic        bus_free;

   assign bus_free = cpu_rst | ~cpu_haltn;

   jts16b_busarb_rr u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .upd     (|ack),
      .upd_idx (ack[1]),
      .pick    (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= ST_IDLE;
         winner     <= REQ_MCU;
         lat_addr   <= '0;
         lat_din    <= '0;
         lat_rnw    <= 1'b1;
         tmo_cnt    <= '0;
         wait_cnt   <= '0;
         bus_quiet  <= 1'b0;
         cpu_brn    <= 1'b1;
         cpu_bgackn <= 1'b1;
         ack        <= 2'b00;
         err        <= 1'b0;
         rdata      <= '0;
         owner      <= 1'b0;
         bus_addr   <= '0;
         bus_din    <= '0;
         bus_rnw    <= 1'b1;
         bus_asn    <= 1'b1;
         bus_dsn    <= 2'b11;
      end else begin
         st         <= st_n;
         winner     <= winner_n;
         lat_addr   <= addr_n;
         lat_din    <= din_n;
         lat_rnw    <= rnw_n;
         tmo_cnt    <= tmo_n;
         wait_cnt   <= wait_n;
         bus_quiet  <= quiet_n;
         cpu_brn    <= brn_n;
         cpu_bgackn <= bgackn_n;
         ack        <= ack_n;
         err        <= err_n;
         rdata      <= rdata_n;
         owner      <= owner_n;
         bus_addr   <= baddr_n;
         bus_din    <= bdin_n;
         bus_rnw    <= brnw_n;
         bus_asn    <= basn_n;
         bus_dsn    <= bdsn_n;
      end
   end

   always_comb begin
      st_n     = st;
      winner_n = winner;
      addr_n   = lat_addr;
      din_n    = lat_din;
      rnw_n    = lat_rnw;
      tmo_n    = tmo_cnt;
      wait_n   = wait_cnt;
      quiet_n  = bus_quiet;
      brn_n    = cpu_brn;
      bgackn_n = cpu_bgackn;
      ack_n    = 2'b00;
      err_n    = 1'b0;
      rdata_n  = rdata;
      owner_n  = owner;
      baddr_n  = bus_addr;
      bdin_n   = bus_din;
      brnw_n   = bus_rnw;
      basn_n   = bus_asn;
      bdsn_n   = bus_dsn;

      case (st)
         ST_IDLE: begin
            if (|req) begin
               winner_n = pick;
               addr_n   = pick ? addr1 : addr0;
               din_n    = pick ? wdata1 : wdata0;
               rnw_n    = rnw[pick];
               tmo_n    = '0;
               if (bus_free) begin
                  // CPU cannot use the bus: start the strobe right away.
                  owner_n = 1'b1;
                  baddr_n = addr_n;
                  bdin_n  = din_n;
                  brnw_n  = rnw_n;
                  bdsn_n  = 2'b00;
                  basn_n  = 1'b0;
                  wait_n  = WAIT_INIT;
                  quiet_n = 1'b0;
                  st_n    = ST_ACCESS;
               end else begin
                  st_n = ST_REQ;
               end
            end
         end

         ST_REQ: begin
            if (bus_free) begin
               brn_n   = 1'b1;
               owner_n = 1'b1;
               st_n    = ST_OWN;
            end else if (cen) begin
               // Grant only counts once BR is out and the CPU has left the bus.
               if (!cpu_brn && !cpu_bgn && cpu_asn && cpu_dtackn) begin
                  bgackn_n = 1'b0;
                  brn_n    = 1'b1;
                  owner_n  = 1'b1;
                  st_n     = ST_OWN;
               end else if (tmo_cnt == TMO_LAST) begin
                  brn_n         = 1'b1;
                  ack_n[winner] = 1'b1;
                  err_n         = 1'b1;
                  st_n          = ST_IDLE;
               end else begin
                  tmo_n = tmo_cnt + 8'd1;
                  brn_n = 1'b0;
               end
            end
         end

         ST_OWN: begin
            baddr_n = lat_addr;
            bdin_n  = lat_din;
            brnw_n  = lat_rnw;
            bdsn_n  = 2'b00;
            basn_n  = 1'b0;
            wait_n  = WAIT_INIT;
            quiet_n = 1'b0;
            st_n    = ST_ACCESS;
         end

         ST_ACCESS: begin
            // Fixed strobe time first, then busy must read low twice in a row.
            if (wait_cnt != 3'd0) begin
               wait_n = wait_cnt - 3'd1;
            end else if (bus_busy) begin
               quiet_n = 1'b0;
            end else if (!bus_quiet) begin
               quiet_n = 1'b1;
            end else begin
               basn_n = 1'b1;
               if (lat_rnw)
                  rdata_n = bus_dout;
               ack_n[winner] = 1'b1;
               st_n          = ST_DONE;
            end
         end

         ST_DONE: begin
            st_n = ST_RELEASE;
         end

         ST_RELEASE: begin
            if (CHAIN_EN && req[~winner] && (!cpu_bgackn || bus_free)) begin
               winner_n = ~winner;
               addr_n   = winner ? addr0 : addr1;
               din_n    = winner ? wdata0 : wdata1;
               rnw_n    = rnw[~winner];
               st_n     = ST_OWN;
            end else begin
               bgackn_n = 1'b1;
               owner_n  = 1'b0;
               bdsn_n   = 2'b11;
               brnw_n   = 1'b1;
               baddr_n  = '0;
               bdin_n   = '0;
               st_n     = ST_IDLE;
            end
         end

         default: st_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_jts16b_busarb.sv
// tb/tb_jts16b_busarb.sv - self-checking bench for jts16b_busarb

module tb_jts16b_busarb;

   localparam int WAITCYC = 3;
   localparam int TIMEOUT = 255;

   logic        clk, rst, cen;
   logic        cpu_rst, cpu_haltn, cpu_brn, cpu_bgn, cpu_bgackn, cpu_asn, cpu_dtackn;
   logic [1:0]  req, rnw, ack;
   logic [22:0] addr0, addr1, bus_addr;
   logic [15:0] wdata0, wdata1, rdata, bus_din, bus_dout;
   logic        err, owner, bus_rnw, bus_asn, bus_busy;
   logic [1:0]  bus_dsn;

   jts16b_busarb #(.WAITCYC(WAITCYC), .TIMEOUT(TIMEOUT), .CHAIN(1)) dut (
      .clk(clk), .rst(rst), .cen(cen),
      .cpu_rst(cpu_rst), .cpu_haltn(cpu_haltn), .cpu_brn(cpu_brn), .cpu_bgn(cpu_bgn),
      .cpu_bgackn(cpu_bgackn), .cpu_asn(cpu_asn), .cpu_dtackn(cpu_dtackn),
      .req(req), .rnw(rnw), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack(ack), .err(err), .rdata(rdata), .owner(owner),
      .bus_addr(bus_addr), .bus_din(bus_din), .bus_rnw(bus_rnw), .bus_asn(bus_asn),
      .bus_dsn(bus_dsn), .bus_dout(bus_dout), .bus_busy(bus_busy)
   );

   typedef struct { logic idx; logic err; logic [15:0] rdata; int tick; } ack_rec_t;
   typedef struct { logic [22:0] addr; logic rnw; logic [15:0] din; logic [1:0] dsn; } stb_rec_t;
   typedef struct {
      logic [1:0] mask; int free; logic [1:0] rw; logic [22:0] a0; logic [22:0] a1;
      logic [15:0] w0; logic [15:0] w1; int gd; logic [15:0] key;
      int exp_first; int exp_windows; logic [15:0] exp_rdata;
   } vec_t;

   ack_rec_t ack_q[$];
   stb_rec_t stb_q[$];
   int checks = 0, failures = 0;
   int cen_ticks = 0, brn_cens = 0, gdel = 2, busy_len = 0, busy_cnt = 0;
   int windows = 0, brn_falls = 0, brn_fall_tick = 0;
   bit grant_en = 1;
   logic busy_force = 0, busy_rand = 0;
   logic [15:0] dout_key = 0;
   logic prev_brn = 1, prev_bgackn = 1, prev_asn = 1;
   logic last_m = 1;            // requester 0 wins the first tie
   logic [15:0] rdata_m = 0;

   assign bus_dout = dout_key ^ bus_addr[15:0];
   assign bus_busy = busy_force | busy_rand;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // cen divider, 68000 grant model, bus memory busy model and monitors
   always @(negedge clk) begin
      if (cen) cen_ticks++;
      if (cpu_brn) brn_cens = 0; else if (cen) brn_cens++;
      cpu_bgn = !(grant_en && !cpu_brn && brn_cens >= gdel);
      cen = ~cen;
      if (bus_asn) begin busy_cnt = 0; busy_rand = 0; end
      else if (busy_cnt < busy_len) begin busy_rand = 1; busy_cnt++; end
      else busy_rand = 0;
      if (prev_brn && !cpu_brn) begin brn_falls++; brn_fall_tick = cen_ticks; end
      if (prev_bgackn && !cpu_bgackn) windows++;
      if (prev_asn && !bus_asn) stb_q.push_back('{bus_addr, bus_rnw, bus_din, bus_dsn});
      if (ack != 2'b00) begin
         chk("ack_onehot", 32'($countones(ack)), 32'd1);
         chk("ack_had_req", 32'(req & ack), 32'(ack));
         ack_q.push_back('{ack[1], err, rdata, cen_ticks});
         req = req & ~ack;
      end
      prev_brn = cpu_brn; prev_bgackn = cpu_bgackn; prev_asn = bus_asn;
   end

   task automatic run_txn(input logic [1:0] mask, input int free, input logic [1:0] rw,
                          input logic [22:0] a0, input logic [22:0] a1,
                          input logic [15:0] w0, input logic [15:0] w1,
                          input int gd, input int bl, input logic [15:0] key);
      int nexp;
      logic ord[2];
      logic [22:0] ea;
      logic [15:0] ew;
      ack_q.delete(); stb_q.delete(); windows = 0; brn_falls = 0;
      cpu_rst = (free == 1); cpu_haltn = !(free == 2);
      gdel = gd; busy_len = bl; dout_key = key; grant_en = 1;
      rnw = rw; addr0 = a0; addr1 = a1; wdata0 = w0; wdata1 = w1;
      @(negedge clk);
      req = mask;
      nexp = (mask == 2'b11) ? 2 : 1;
      ord[0] = (mask == 2'b01) ? 1'b0 : (mask == 2'b10) ? 1'b1 : ~last_m;
      ord[1] = ~ord[0];
      for (int c = 0; c < 3000 && ack_q.size() < nexp; c++) @(negedge clk);
      repeat (6) @(negedge clk);
      chk("ack_count", ack_q.size(), nexp);
      chk("strobe_count", stb_q.size(), nexp);
      for (int k = 0; k < nexp; k++) begin
         ea = ord[k] ? a1 : a0;
         ew = ord[k] ? w1 : w0;
         if (rw[ord[k]]) rdata_m = key ^ ea[15:0];
         last_m = ord[k];
         if (k < ack_q.size()) begin
            chk("ack_idx", 32'(ack_q[k].idx), 32'(ord[k]));
            chk("ack_err", 32'(ack_q[k].err), 32'd0);
            chk("ack_rdata", 32'(ack_q[k].rdata), 32'(rdata_m));
         end
         if (k < stb_q.size()) begin
            chk("strobe_addr", 32'(stb_q[k].addr), 32'(ea));
            chk("strobe_rnw", 32'(stb_q[k].rnw), 32'(rw[ord[k]]));
            chk("strobe_dsn", 32'(stb_q[k].dsn), 32'd0);
            if (!rw[ord[k]]) chk("strobe_din", 32'(stb_q[k].din), 32'(ew));
         end
      end
      chk("bgack_windows", windows, (free != 0) ? 0 : 1);
      chk("brn_falls", brn_falls, (free != 0) ? 0 : 1);
      chk("owner_after", 32'(owner), 32'd0);
      chk("bgackn_after", 32'(cpu_bgackn), 32'd1);
      req = 0; cpu_rst = 0; cpu_haltn = 1; busy_len = 0;
   endtask

   vec_t tbl[5];
   int n;
   bit stuck_ok;

   initial begin
      tbl[0] = '{2'b01, 0, 2'b01, 23'h0C0000, 23'h000000, 16'h0000, 16'h0000, 4, 16'h1234, 0, 1, 16'h1234};
      tbl[1] = '{2'b11, 0, 2'b01, 23'h000100, 23'h400010, 16'h0000, 16'h3F00, 3, 16'h00FF, 1, 1, 16'h01FF};
      tbl[2] = '{2'b01, 2, 2'b01, 23'h000055, 23'h000000, 16'h0000, 16'h0000, 1, 16'hA000, 0, 0, 16'hA055};
      tbl[3] = '{2'b11, 1, 2'b10, 23'h000200, 23'h000002, 16'hBEEF, 16'h0000, 1, 16'h1111, 1, 0, 16'h1113};
      tbl[4] = '{2'b10, 0, 2'b00, 23'h000000, 23'h7FFFFF, 16'h0000, 16'hCAFE, 2, 16'h5555, 1, 1, 16'h1113};

      rst = 1; cen = 0; cpu_rst = 0; cpu_haltn = 1; cpu_bgn = 1; cpu_asn = 1; cpu_dtackn = 1;
      req = 0; rnw = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_brn", 32'(cpu_brn), 32'd1);
      chk("rst_bgackn", 32'(cpu_bgackn), 32'd1);
      chk("rst_ack_err", 32'({ack, err}), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_bus_ctl", 32'({bus_asn, bus_dsn, bus_rnw}), 32'hF);
      chk("rst_bus_data", 32'({bus_addr, bus_din} != 0), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);

      // table vectors
      for (int v = 0; v < 5; v++) begin
         run_txn(tbl[v].mask, tbl[v].free, tbl[v].rw, tbl[v].a0, tbl[v].a1,
                 tbl[v].w0, tbl[v].w1, tbl[v].gd, 0, tbl[v].key);
         if (ack_q.size() > 0) chk("vec_first", 32'(ack_q[0].idx), 32'(tbl[v].exp_first));
         chk("vec_windows", windows, tbl[v].exp_windows);
         chk("vec_rdata", 32'(rdata), 32'(tbl[v].exp_rdata));
      end

      // grant never given: timeout with err
      ack_q.delete(); stb_q.delete(); windows = 0; grant_en = 0;
      rnw = 2'b01; addr0 = 23'h000123;
      @(negedge clk); req = 2'b01;
      for (int c = 0; c < 1500 && ack_q.size() == 0; c++) @(negedge clk);
      chk("tmo_ack_count", ack_q.size(), 1);
      if (ack_q.size() > 0) begin
         chk("tmo_err", 32'(ack_q[0].err), 32'd1);
         chk("tmo_idx", 32'(ack_q[0].idx), 32'd0);
         chk("tmo_ticks", ack_q[0].tick - brn_fall_tick, TIMEOUT - 1);
      end
      last_m = 0;
      repeat (4) @(negedge clk);
      chk("tmo_brn", 32'(cpu_brn), 32'd1);
      chk("tmo_no_strobe", stb_q.size(), 0);
      chk("tmo_no_bgack", windows, 0);
      chk("tmo_rdata_kept", 32'(rdata), 32'(rdata_m));
      req = 0; grant_en = 1;

      // halted CPU: no handshake, fixed access latency
      brn_falls = 0; windows = 0; cpu_haltn = 0; dout_key = 16'h4321;
      rnw = 2'b01; addr0 = 23'h000010;
      @(negedge clk); req = 2'b01;
      n = 0;
      while (bus_asn && n < 10) begin @(negedge clk); n++; end
      chk("halt_asn_latency", 32'(n <= 2), 32'd1);
      n = 0;
      while (ack != 2'b01 && n < 50) begin @(negedge clk); n++; end
      chk("halt_ack_latency", n, WAITCYC + 2);
      chk("halt_rdata", 32'(rdata), 32'h4331);
      rdata_m = 16'h4331; last_m = 0;
      repeat (6) @(negedge clk);
      chk("halt_no_handshake", brn_falls + windows, 0);

      // memory busy stretches the strobe
      busy_force = 1; dout_key = 16'h0F0F; rnw = 2'b10; addr1 = 23'h000003;
      @(negedge clk); req = 2'b10;
      n = 0;
      while (bus_asn && n < 10) begin @(negedge clk); n++; end
      stuck_ok = 1;
      repeat (20) begin
         @(negedge clk);
         if (bus_asn || ack != 2'b00) stuck_ok = 0;
      end
      chk("busy_holds_asn", 32'(stuck_ok), 32'd1);
      busy_force = 0;
      n = 0;
      while (ack != 2'b10 && n < 20) begin @(negedge clk); n++; end
      chk("busy_ack_delay", n, 2);
      chk("busy_rdata", 32'(rdata), 32'h0F0C);
      rdata_m = 16'h0F0C; last_m = 1;
      repeat (6) @(negedge clk);

      // asynchronous reset in the middle of an access
      ack_q.delete(); dout_key = 16'h7777; rnw = 2'b01; addr0 = 23'h000040;
      @(negedge clk); req = 2'b01;
      n = 0;
      while (bus_asn && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("arst_cpu", 32'({cpu_brn, cpu_bgackn}), 32'h3);
      chk("arst_ack_err_owner", 32'({ack, err, owner}), 32'd0);
      chk("arst_rdata", 32'(rdata), 32'd0);
      chk("arst_bus_ctl", 32'({bus_asn, bus_dsn, bus_rnw}), 32'hF);
      chk("arst_bus_data", 32'({bus_addr, bus_din} != 0), 32'd0);
      req = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
      chk("arst_no_ack", ack_q.size(), 0);
      last_m = 1; rdata_m = 0;

      // both requests together right after reset: requester 0 first
      run_txn(2'b11, 2, 2'b11, 23'h000011, 23'h000022, 16'h0, 16'h0, 1, 0, 16'h2000);
      if (ack_q.size() > 0) chk("both_from_reset", 32'(ack_q[0].idx), 32'd0);

      // randomized traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         logic [1:0] m;
         m = 2'($urandom_range(1, 3));
         run_txn(m, $urandom_range(0, 2), 2'($urandom), 23'($urandom), 23'($urandom),
                 16'($urandom), 16'($urandom), $urandom_range(1, 5), $urandom_range(0, 6),
                 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
